// File: rtl/fib_pkg.sv
// Shared types and codes for the fib sequencer and its datapath.
// State encoding, din mux selects and register addresses.
package fib_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT0,
    INIT1,
    ADD,
    MOV0,
    MOV1,
    DONE
  } state_t;

  localparam logic [1:0] DIN_ZERO  = 2'd0;
  localparam logic [1:0] DIN_ONE   = 2'd1;
  localparam logic [1:0] DIN_SUM   = 2'd2;
  localparam logic [1:0] DIN_PASSA = 2'd3;

  localparam logic [3:0] RA_R0 = 4'd0;
  localparam logic [3:0] RA_R1 = 4'd1;
  localparam logic [3:0] RA_R2 = 4'd2;

endpackage

// File: rtl/fib_seq_ctrl.sv
// Fibonacci sequencer: steps the register file through init plus
// n rounds of {add, move, move}, leaving F(n) in r0.
module fib_seq_ctrl
  import fib_pkg::*;
#(
  parameter int NW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] n,
  input  logic          alu_cy,
  output logic          rf_rw,
  output logic [3:0]    rf_da,
  output logic [3:0]    rf_aa,
  output logic [3:0]    rf_ba,
  output logic [1:0]    din_sel,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  state_t        state;
  state_t        state_d;
  logic [NW-1:0] cnt;
  logic [NW-1:0] n_q;
  logic [NW-1:0] cnt_nx;
  logic [NW:0]   cnt_p1;
  logic          accept;
  logic          early_cy;

  assign cnt_nx = cnt + 1'b1;
  assign cnt_p1 = {1'b0, cnt} + {{NW{1'b0}}, 1'b1};
  assign accept = (state == IDLE) && start;

  // Only carries before the last add reach r0; the last one
  // truncates r1 alone and is not an overflow of the result.
  assign early_cy = (state == ADD) && alu_cy
                 && (cnt_p1 < {1'b0, n_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      n_q   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        n_q <= n;
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        if (state == MOV1) cnt <= cnt_nx;
        if (early_cy)      ovf <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    rf_rw   = 1'b0;
    rf_da   = RA_R0;
    rf_aa   = RA_R0;
    rf_ba   = RA_R0;
    din_sel = DIN_ZERO;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = INIT0;
      end
      INIT0: begin
        rf_rw   = 1'b1;
        rf_da   = RA_R0;
        din_sel = DIN_ZERO;
        state_d = INIT1;
      end
      INIT1: begin
        rf_rw   = 1'b1;
        rf_da   = RA_R1;
        din_sel = DIN_ONE;
        state_d = (n_q == '0) ? DONE : ADD;
      end
      ADD: begin
        rf_rw   = 1'b1;
        rf_aa   = RA_R0;
        rf_ba   = RA_R1;
        rf_da   = RA_R2;
        din_sel = DIN_SUM;
        state_d = MOV0;
      end
      MOV0: begin
        rf_rw   = 1'b1;
        rf_aa   = RA_R1;
        rf_da   = RA_R0;
        din_sel = DIN_PASSA;
        state_d = MOV1;
      end
      MOV1: begin
        rf_rw   = 1'b1;
        rf_aa   = RA_R2;
        rf_da   = RA_R1;
        din_sel = DIN_PASSA;
        state_d = (cnt_nx == n_q) ? DONE : ADD;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Bench for fib_seq_ctrl: an 8-bit register file and adder
// around the sequencer, with a scoreboard of completed runs.
module tb_fib_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] n_in = '0;
  logic       alu_cy;
  logic       rf_rw;
  logic [3:0] rf_da;
  logic [3:0] rf_aa;
  logic [3:0] rf_ba;
  logic [1:0] din_sel;
  logic       busy;
  logic       done;
  logic       ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fib_seq_ctrl #(.NW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n_in),
    .alu_cy(alu_cy), .rf_rw(rf_rw), .rf_da(rf_da),
    .rf_aa(rf_aa), .rf_ba(rf_ba), .din_sel(din_sel),
    .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] rf [9];
  logic [7:0] adata;
  logic [7:0] bdata;
  logic [8:0] sum;
  logic [7:0] din;

  function automatic logic [7:0] rd(input logic [3:0] a);
    return (a < 4'd9) ? rf[a] : 8'h00;
  endfunction

  always_comb begin
    adata  = rd(rf_aa);
    bdata  = rd(rf_ba);
    sum    = {1'b0, adata} + {1'b0, bdata};
    alu_cy = sum[8];
    case (din_sel)
      2'd0:    din = 8'd0;
      2'd1:    din = 8'd1;
      2'd2:    din = sum[7:0];
      default: din = adata;
    endcase
  end

  always @(posedge clk)
    if (rf_rw && rf_da < 4'd9) rf[rf_da] <= din;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] fib_mod(input int k);
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd1;
    logic [7:0] t;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  typedef struct {
    logic [7:0] r0;
    logic [7:0] r1;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  // Scoreboard: every done pulse must match the oldest pending run.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("r0", rf[0], e.r0);
        chk("r1", rf[1], e.r1);
        chk("ovf", ovf, e.ovf);
        chk("busy_in_done", busy, 1);
      end
    end
  end

  task automatic run(input logic [7:0] nv, input logic [7:0] r0,
                     input logic [7:0] r1, input logic ov,
                     input bit hold);
    exp_t e;
    bit   seen = 0;
    @(negedge clk);
    n_in  = nv;
    start = 1'b1;
    e.r0  = r0;
    e.r1  = r1;
    e.ovf = ov;
    e.cyc = cyc + 3 + 3 * int'(nv);
    sb.push_back(e);
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    if (hold) n_in = 8'd3;
    else start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (hold) n_in = (i % 2 == 0) ? 8'd3 : 8'd200;
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_rw", rf_rw, 0);
    chk("idle_done", done, 0);
    chk("idle_ovf_hold", ovf, ov);
  endtask

  typedef struct {
    logic [7:0] n;
    logic [7:0] r0;
    logic [7:0] r1;
    logic       ovf;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{8'd0,  8'd0,   8'd1,   1'b0};
    tbl[1] = '{8'd1,  8'd1,   8'd1,   1'b0};
    tbl[2] = '{8'd2,  8'd1,   8'd2,   1'b0};
    tbl[3] = '{8'd10, 8'd55,  8'd89,  1'b0};
    tbl[4] = '{8'd13, 8'd233, 8'd121, 1'b0};
    tbl[5] = '{8'd14, 8'd121, 8'd98,  1'b1};
    tbl[6] = '{8'd5,  8'd5,   8'd8,   1'b0};

    #1;
    chk("rst_outs", {rf_rw, rf_da, rf_aa, rf_ba, din_sel,
                     busy, done}, 0);
    chk("rst_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", {rf_rw, rf_da, busy, done}, 0);

    foreach (tbl[i])
      run(tbl[i].n, tbl[i].r0, tbl[i].r1, tbl[i].ovf, 1'b0);

    run(8'd10, 8'd55, 8'd89, 1'b0, 1'b1);
    run(8'd255, fib_mod(255), fib_mod(256), 1'b1, 1'b0);

    // Reset in the middle of an n=10 run, during an ADD state.
    @(negedge clk);
    n_in  = 8'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      bit hit = 0;
      for (int i = 0; i < 200; i++) begin
        if (rf_rw && rf_da == 4'd2) begin
          hit = 1;
          break;
        end
        @(negedge clk);
      end
      chk("reach_add", hit, 1);
    end
    rst = 1'b1;
    #1;
    chk("midrst_outs", {rf_rw, rf_da, rf_aa, rf_ba, din_sel,
                        busy, done}, 0);
    chk("midrst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    run(8'd4, 8'd3, 8'd5, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
